// File: rtl/trace_request_scheduler.sv
// trace_request_scheduler
// Buffers time-stamped trace requests in a circular FIFO and releases the
// head entry once the CPU-cycle counter reaches its timestamp. While the
// controller queue is empty the counter may jump straight to the head
// timestamp so idle gaps in the trace cost a single clock.
module trace_request_scheduler #(
  parameter int ADDR_W       = 36,
  parameter int CMD_W        = 2,
  parameter int TIME_W       = 64,
  parameter int DEPTH        = 16,
  parameter int FAST_FORWARD = 1
) (
  input  logic                         clock,
  input  logic                         reset,
  // trace side
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [TIME_W-1:0]            in_time,
  input  logic [CMD_W-1:0]             in_cmd,
  input  logic [ADDR_W-1:0]            in_addr,
  input  logic                         in_last,
  // controller side
  input  logic                         ctrl_empty,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [TIME_W-1:0]            out_time,
  output logic [CMD_W-1:0]             out_cmd,
  output logic [ADDR_W-1:0]            out_addr,
  // status
  output logic [TIME_W-1:0]            cycle,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         done,
  output logic                         order_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  ONE_COUNT  = CNT_W'(1);
  localparam logic [TIME_W-1:0] TIME_MAX   = '1;

  typedef struct packed {
    logic [TIME_W-1:0] t;
    logic [CMD_W-1:0]  cmd;
    logic [ADDR_W-1:0] addr;
  } entry_t;

  // FILL: still accepting trace; DRAIN: last entry seen, FIFO not yet empty;
  // DONE: everything issued, only reset leaves this state.
  typedef enum logic [1:0] {
    FILL  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;

  entry_t            mem [DEPTH];
  entry_t            head;
  entry_t            push_entry;

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [TIME_W-1:0] last_time;
  logic [TIME_W-1:0] push_time;
  logic              last_seen;
  logic              not_empty;
  logic              push;
  logic              pop;
  logic              fast_fwd;

  assign head      = mem[rd_ptr];
  assign not_empty = (count != '0);
  assign last_seen = (state != FILL);

  // in_ready looks only at registered state, so a pop never frees a slot
  // for a push in the same cycle.
  assign in_ready  = !reset && (count < FULL_COUNT) && !last_seen;
  assign push      = in_valid && in_ready;

  // The head cannot change and cycle never decreases, so once out_valid
  // rises it stays up until the entry is popped.
  assign out_valid = not_empty && (cycle >= head.t);
  assign pop       = out_valid && out_ready;

  // Outputs read as zero while the FIFO is empty so stale storage never
  // leaks out after reset.
  assign out_time  = not_empty ? head.t    : '0;
  assign out_cmd   = not_empty ? head.cmd  : '0;
  assign out_addr  = not_empty ? head.addr : '0;

  assign done      = (state == DONE);

  // Timestamps are clamped so the FIFO is always non-decreasing in time;
  // a late entry is released as soon as its predecessor's time is reached.
  assign push_time       = (in_time < last_time) ? last_time : in_time;
  assign push_entry.t    = push_time;
  assign push_entry.cmd  = in_cmd;
  assign push_entry.addr = in_addr;

  // Jump only when counting would take more than one clock to reach the
  // head; written as cycle < t-1 so the all-ones counter cannot wrap.
  assign fast_fwd = (FAST_FORWARD != 0) && not_empty && ctrl_empty &&
                    (head.t != '0) && (cycle < (head.t - 1'b1));

  // Phase register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= FILL;
    end else begin
      state <= state_next;
    end
  end

  // Phase transitions: final entry accepted, then final entry popped.
  always_comb begin
    // NOTE: every variable assigned in an always_comb gets a default first,
    // otherwise paths that skip the assignment infer a latch.
    state_next = state;
    case (state)
      FILL: begin
        if (push && in_last) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        // No pushes happen here, so the FIFO empties exactly when the
        // last remaining entry is popped.
        if (!not_empty || (pop && (count == ONE_COUNT))) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = DONE;
      end
      default: begin
        state_next = FILL;
      end
    endcase
  end

  // Entry storage written on every accepted push.
  always_ff @(posedge clock) begin
    // NOTE: the storage array has no reset; occupancy and pointers are
    // reset, so slots are never read before they have been written.
    if (push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  // Pointers, occupancy, timestamp tracking and the CPU-cycle counter.
  always_ff @(posedge clock) begin
    // NOTE: state is updated with non-blocking assignments so every
    // register samples values from before this edge, whatever the order.
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      cycle     <= '0;
      last_time <= '0;
      order_err <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr    <= wr_ptr + 1'b1;
        last_time <= push_time;
        if (in_time < last_time) begin
          order_err <= 1'b1;
        end
      end

      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (fast_fwd) begin
        cycle <= head.t;
      end else if (cycle != TIME_MAX) begin
        cycle <= cycle + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_trace_request_scheduler.sv
// Self-checking bench for trace_request_scheduler. A queue-based reference
// model tracks the pending requests, the CPU-cycle counter and the sticky
// flags; every cycle the DUT outputs are compared against it.
module tb_trace_request_scheduler;

  localparam int ADDR_W       = 36;
  localparam int CMD_W        = 2;
  localparam int TIME_W       = 16;
  localparam int DEPTH        = 4;
  localparam int FAST_FORWARD = 1;
  localparam int CNT_W        = $clog2(DEPTH + 1);
  localparam longint TMAX     = (64'd1 << TIME_W) - 1;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [TIME_W-1:0]   in_time = '0;
  logic [CMD_W-1:0]    in_cmd = '0;
  logic [ADDR_W-1:0]   in_addr = '0;
  logic                in_last = 1'b0;
  logic                ctrl_empty = 1'b0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [TIME_W-1:0]   out_time;
  logic [CMD_W-1:0]    out_cmd;
  logic [ADDR_W-1:0]   out_addr;
  logic [TIME_W-1:0]   cycle;
  logic [CNT_W-1:0]    count;
  logic                done;
  logic                order_err;

  always #5 clock = ~clock;

  trace_request_scheduler #(
    .ADDR_W       (ADDR_W),
    .CMD_W        (CMD_W),
    .TIME_W       (TIME_W),
    .DEPTH        (DEPTH),
    .FAST_FORWARD (FAST_FORWARD)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_time    (in_time),
    .in_cmd     (in_cmd),
    .in_addr    (in_addr),
    .in_last    (in_last),
    .ctrl_empty (ctrl_empty),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_time   (out_time),
    .out_cmd    (out_cmd),
    .out_addr   (out_addr),
    .cycle      (cycle),
    .count      (count),
    .done       (done),
    .order_err  (order_err)
  );

  // ---------------- reference model ----------------
  typedef struct {
    longint            t;
    int unsigned       cmd;
    logic [ADDR_W-1:0] addr;
  } req_t;

  req_t   q[$];
  longint m_cycle;
  longint m_last_time;
  bit     m_last_seen;
  bit     m_done;
  bit     m_order_err;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    q.delete();
    m_cycle     = 0;
    m_last_time = 0;
    m_last_seen = 0;
    m_done      = 0;
    m_order_err = 0;
  endtask

  function automatic bit m_in_ready();
    return !reset && (q.size() < DEPTH) && !m_last_seen;
  endfunction

  function automatic bit m_out_valid();
    if (q.size() == 0) return 1'b0;
    return m_cycle >= q[0].t;
  endfunction

  // One clock: compare outputs mid-cycle, then advance the model at the edge.
  // Called right after a falling edge with the inputs for this cycle set.
  task automatic step();
    bit     push;
    bit     pop;
    bit     rst;
    bit     ce;
    longint t_in;
    req_t   r;
    #1;
    check("in_ready",  in_ready,  m_in_ready());
    check("out_valid", out_valid, m_out_valid());
    check("cycle",     cycle,     m_cycle);
    check("count",     count,     q.size());
    check("done",      done,      m_done);
    check("order_err", order_err, m_order_err);
    if (m_out_valid()) begin
      check("out_time", out_time, q[0].t);
      check("out_cmd",  out_cmd,  q[0].cmd);
      check("out_addr", out_addr, q[0].addr);
    end
    push   = in_valid && m_in_ready();
    pop    = m_out_valid() && out_ready;
    rst    = reset;
    ce     = ctrl_empty;
    t_in   = longint'(in_time);
    r.t    = (t_in < m_last_time) ? m_last_time : t_in;
    r.cmd  = in_cmd;
    r.addr = in_addr;
    @(posedge clock);
    if (rst) begin
      m_reset();
    end else begin
      if (FAST_FORWARD != 0 && q.size() > 0 && ce && (m_cycle + 1 < q[0].t))
        m_cycle = q[0].t;
      else if (m_cycle < TMAX)
        m_cycle = m_cycle + 1;
      if (pop) void'(q.pop_front());
      if (push) begin
        if (t_in < m_last_time) m_order_err = 1;
        m_last_time = r.t;
        q.push_back(r);
        if (in_last) m_last_seen = 1;
      end
      if (m_last_seen && q.size() == 0) m_done = 1;
    end
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_last  = 1'b0;
    reset    = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check("rst_in_ready",  in_ready,  1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_time",  out_time,  0);
    check("rst_out_cmd",   out_cmd,   0);
    check("rst_out_addr",  out_addr,  0);
    check("rst_cycle",     cycle,     0);
    check("rst_count",     count,     0);
    check("rst_done",      done,      0);
    check("rst_order_err", order_err, 0);
  endtask

  // Offer one entry until the model says it is taken (bounded).
  task automatic push_req(input longint t, input int unsigned cmd,
                          input logic [ADDR_W-1:0] addr, input bit last);
    bit acc;
    acc      = 1'b0;
    in_valid = 1'b1;
    in_time  = TIME_W'(t);
    in_cmd   = CMD_W'(cmd);
    in_addr  = addr;
    in_last  = last;
    for (int i = 0; i < 200 && !acc; i++) begin
      acc = m_in_ready();
      step();
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: entry time %0d never accepted", t);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Step until the model expects out_valid (bounded).
  task automatic wait_valid(input string tag, input int bound);
    int i;
    for (i = 0; i < bound && !m_out_valid(); i++) step();
    if (!m_out_valid()) begin
      checks++;
      errors++;
      $display("FAIL %s: out_valid not expected within %0d cycles", tag, bound);
    end
  endtask

  initial begin
    m_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);

    // ---- basic release by counting ----
    do_reset();
    ctrl_empty = 1'b0;
    out_ready  = 1'b1;
    push_req(5, 0, 36'h1_0000_0040, 1'b0);
    wait_valid("basic_wait", 50);
    check("basic_cycle", cycle, 5);
    check("basic_addr", out_addr, 36'h1_0000_0040);
    step();
    check("basic_count", count, 0);
    idle(2);

    // ---- fast-forward over an idle gap ----
    do_reset();
    ctrl_empty = 1'b1;
    out_ready  = 1'b0;
    idle(3);
    push_req(1000, 1, 36'hABC, 1'b0);
    step();
    check("ff_cycle", cycle, 1000);
    check("ff_valid", out_valid, 1);
    out_ready = 1'b1;
    step();
    idle(2);

    // ---- no jump while the controller is busy ----
    do_reset();
    ctrl_empty = 1'b0;
    out_ready  = 1'b0;
    idle(3);
    push_req(1000, 1, 36'hABC, 1'b0);
    wait_valid("busy_wait", 1100);
    check("busy_cycle", cycle, 1000);
    out_ready = 1'b1;
    step();

    // ---- full FIFO and backpressure ----
    do_reset();
    out_ready = 1'b0;
    for (int t = 0; t < 4; t++) push_req(t, t % 3, ADDR_W'(t * 64), 1'b0);
    in_valid = 1'b1;
    in_time  = TIME_W'(4);
    in_cmd   = '0;
    in_addr  = ADDR_W'(256);
    #1;
    check("full_ready", in_ready, 0);
    check("full_count", count, 4);
    out_ready = 1'b1;
    step();
    check("refill_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    idle(8);

    // ---- out-of-order timestamp ----
    do_reset();
    out_ready = 1'b0;
    push_req(10, 0, 36'h10, 1'b0);
    push_req(7, 2, 36'h7, 1'b0);
    check("order_flag", order_err, 1);
    wait_valid("order_wait", 30);
    out_ready = 1'b1;
    step();
    check("order_time", out_time, 10);
    check("order_addr", out_addr, 36'h7);
    idle(3);

    // ---- completion ----
    do_reset();
    out_ready  = 1'b1;
    ctrl_empty = 1'b0;
    push_req(2, 0, 36'h100, 1'b0);
    push_req(4, 1, 36'h200, 1'b0);
    push_req(6, 2, 36'h300, 1'b1);
    check("last_ready", in_ready, 0);
    for (int i = 0; i < 40 && !m_done; i++) step();
    check("done_set", done, 1);
    idle(5);
    check("done_hold", done, 1);

    // ---- reset in the middle of a trace ----
    do_reset();
    out_ready = 1'b0;
    push_req(10, 1, 36'h1, 1'b0);
    push_req(5, 1, 36'h2, 1'b0);
    idle(12);
    do_reset();
    idle(2);

    // ---- counter saturation ----
    do_reset();
    ctrl_empty = 1'b1;
    out_ready  = 1'b0;
    push_req(TMAX, 3, 36'hF_FFFF_FFFF, 1'b0);
    step();
    idle(3);
    check("sat_cycle", cycle, TMAX);
    check("sat_valid", out_valid, 1);
    out_ready = 1'b1;
    step();
    push_req(TMAX, 0, 36'h5, 1'b0);
    idle(3);
    check("sat_drain", count, 0);

    // ---- randomized traffic ----
    for (int round = 0; round < 4; round++) begin
      do_reset();
      for (int n = 0; n < 400; n++) begin
        longint t;
        t = m_last_time + longint'($urandom_range(0, 30));
        if ($urandom_range(0, 7) == 0) begin
          t = m_last_time - longint'($urandom_range(1, 20));
          if (t < 0) t = 0;
        end
        in_valid   = ($urandom_range(0, 2) != 0);
        in_time    = TIME_W'(t);
        in_cmd     = CMD_W'($urandom_range(0, 2));
        in_addr    = {4'($urandom), 32'($urandom)};
        in_last    = ($urandom_range(0, 149) == 0);
        out_ready  = (round == 3) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 3) != 0);
        ctrl_empty = ($urandom_range(0, 1) == 1);
        step();
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/trace_request_scheduler.md
# trace_request_scheduler

Parametrised, synthesizable successor to the trace-driven request source for the DDR4 controller testbench. Buffers time-stamped CPU requests (timestamp, command, address) in a DEPTH-entry FIFO. Releases each request to the controller when an internal CPU-cycle counter reaches its timestamp. When the controller queue is empty, the counter fast-forwards over idle gaps. Sits between the trace source (file reader or stimulus generator) and the controller's request queue, with ready/valid on both sides.

## Interface
- ADDR_W, 36, request address width
- CMD_W, 2, command width (0 read, 1 write, 2 ifetch; opaque here)
- TIME_W, 64, timestamp and cycle-counter width
- DEPTH, 16, FIFO entries; power of two, ≥2
- FAST_FORWARD, 1, 1 enables idle-gap skipping; 0 makes the counter strictly +1 per clock

- clock  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  trace entry offered
- in_ready  out  1  entry accepted when in_valid && in_ready
- in_time  in  TIME_W  CPU-cycle timestamp
- in_cmd  in  CMD_W  command
- in_addr  in  ADDR_W  address
- in_last  in  1  qualifies the final trace entry
- ctrl_empty  in  1  controller request queue empty
- out_valid  out  1  head request due
- out_ready  in  1  controller accepts; pop when out_valid && out_ready
- out_time, out_cmd, out_addr  out  TIME_W/CMD_W/ADDR_W  head entry fields
- cycle  out  TIME_W  current CPU-cycle counter
- count  out  $clog2(DEPTH+1)  FIFO occupancy
- done  out  1  sticky: last entry issued and FIFO drained
- order_err  out  1  sticky: a non-monotonic timestamp was seen

## Operation
- **FIFO:** circular, write and read pointers of $clog2(DEPTH) bits that wrap at DEPTH, plus an occupancy counter. in_ready = (count < DEPTH) && !last_seen.
- **Push:** store {time', cmd, addr}.
  - time' = max(in_time, last_time), where last_time is the last accepted timestamp (0 after reset).
  - If in_time < last_time, set order_err (sticky).
  - If in_last is set, set last_seen; no further pushes until reset.
- **Counter:** cycle increments by 1 every clock, saturating at all-ones.
  - Fast-forward: if FAST_FORWARD=1, count>0, ctrl_empty=1 and cycle+1 < head.time, then cycle loads head.time instead of incrementing.
- **Release:** out_valid = (count>0) && (cycle >= head.time). out_* are driven from the FIFO head and are meaningful only when out_valid=1.
  - Once asserted, out_valid and out_* hold until popped; the head cannot change and cycle is monotonic.
- **Done:** set on the clock where last_seen=1, count=0 and no push occurs; also set when the final pop leaves count=0 with last_seen=1. Holds until reset.
- **States:** FILL (last_seen=0) → DRAIN (last_seen=1, count>0) → DONE. An in_last push into an empty FIFO goes FILL→DRAIN. The only exit from DONE is reset.

## Timing
- **Reset (synchronous, 1 cycle):**
  - in_ready=0 during reset; 1 on the first cycle after reset.
  - out_valid=0, out_*=0, cycle=0, count=0, done=0, order_err=0.
  - Pointers, last_time and last_seen cleared; buffered entries discarded. Reset mid-trace discards everything.
- **Latency:** an entry pushed at edge N is visible at the head after edge N. out_valid can first be 1 in the cycle after acceptance; there is no same-cycle bypass.
- **Simultaneous push and pop:** count unchanged, both pointers advance.
- **Full FIFO:** in_ready=0 even if a pop occurs the same cycle, so in_ready depends only on registered state.
- **Fast-forward:** the jump takes effect at the edge; out_valid rises in the following cycle. With ctrl_empty=0 there is no jump.
- **Stall:** out_valid=1 with out_ready=0 stalls the head; cycle keeps advancing.
- **Saturation:** cycle at 2^TIME_W−1 stays there. Entries with time ≤ that value still release.

## Test plan
- **Basic release, FAST_FORWARD=0, out_ready=1:** push (time 5, cmd 0, addr 0x1_0000_0040).
  - out_valid rises in the cycle where cycle=5; one pop; count returns to 0.
- **Fast-forward:** ctrl_empty=1; push (time 1000, cmd 1, addr 0xABC) at cycle 3.
  - cycle loads 1000 at the next edge; out_valid=1 the cycle after.
  - With ctrl_empty=0, out_valid waits until cycle=1000 by counting.
- **Full/backpressure, DEPTH=4:** out_ready=0; push 5 entries with times 0..4.
  - in_ready drops after 4 accepts, count=4.
  - Release out_ready: pops come out in order 0..4; the 5th is accepted the cycle after the first pop.
- **Order error:** push times 10 then 7.
  - order_err=1 after the 2nd accept; the 2nd entry is issued with out_time=10.
- **Completion:** push 3 entries, the third with in_last=1.
  - in_ready=0 afterward; done=1 the cycle after the 3rd pop and remains 1.
  - Assert reset mid-run: all outputs return to reset values next cycle.
